rover_seg_display_mux: RTL and testbench
========================================

Name: rover_seg_display_mux

Overview:
- Parametrised N-digit multiplexed 7-segment driver for the delivery rover status panel. Successor to the fixed 4-digit speed/direction display.
- The controller FSM supplies glyph codes per digit, with decimal-point, blink and fault inputs.
- The block adds tear-free double-buffered updates, anti-ghosting dead time, per-digit blinking, a sticky fault overlay, and configurable output polarity.
- Sits between the rover control logic and the board's SEG_*/DIG_* pins.

Parameters:
- NUM_DIGITS, 4: digits driven (2..8).
- REFRESH_DIV, 65536: clock cycles per digit slot (>= DEAD_CYCLES+2).
- DEAD_CYCLES, 64: cycles at the start of each slot with all digits off.
- BLINK_FRAMES, 32: full frames per blink half-period.
- SEG_ACTIVE_LOW, 1: 1 means segment outputs are inverted (0 = lit).
- DIG_ACTIVE_LOW, 1: 1 means digit enables are inverted (0 = enabled).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- load, in, 1: one-cycle strobe that captures glyph_in/dp_in/blink_in into the staging buffer.
- glyph_in, in, 5*NUM_DIGITS: 5-bit glyph code per digit; digit 0 is the rightmost, in bits [4:0].
- dp_in, in, NUM_DIGITS: decimal point per digit.
- blink_in, in, NUM_DIGITS: blink enable per digit.
- fault, in, 1: overcurrent fault, level input.
- fault_clr, in, 1: one-cycle strobe that clears the latched fault.
- seg, out, 8: {DP,G,F,E,D,C,B,A}, polarity per SEG_ACTIVE_LOW.
- dig, out, NUM_DIGITS: digit enables; dig[0] is the rightmost digit; polarity per DIG_ACTIVE_LOW.
- frame_done, out, 1: one-cycle pulse when the last digit slot ends.
- load_pending, out, 1: staging buffer holds data not yet displayed.
- fault_active, out, 1: latched fault state.

Behaviour:
- Reset (async assert, sync release):
  - all counters 0, digit index 0, blink phase 0;
  - active and staging glyphs = BLANK (16), dp = 0, blink = 0;
  - load_pending = 0, fault latch = 0, frame_done = 0;
  - seg and dig at their "off" level (seg = 8'hFF and dig all 1 with default polarity).
- Prescaler:
  - counts 0..REFRESH_DIV-1;
  - at the terminal count, digit index advances (NUM_DIGITS-1 wraps to 0).
- Wrap and frame_done:
  - on the wrap from index NUM_DIGITS-1 to 0, frame_done pulses 1 cycle, coincident with the index change.
- Dead time:
  - while prescaler < DEAD_CYCLES, dig is all off and seg is off.
  - otherwise exactly one dig bit is on (the current index) and seg shows that digit's decoded pattern.
- Output registers:
  - seg and dig are registered together and change on the same edge.
  - one-cycle latency from prescaler/index to pins.
- Glyph decode (internal gfedcba, active-high):
  - 0-15 are hex 0-9, A, b, C, d, E, F (0=0x3F, 1=0x06, 7=0x07, E=0x79, F=0x71, b=0x7C);
  - 16 = blank 0x00; 17 = dash 0x40; 18 = L 0x38; 19 = r 0x50;
  - 20 = o 0x5C; 21 = u 0x1C; 22 = P 0x73; 23 = H 0x76;
  - 24-31 = blank.
  - DP bit = dp of that digit.
- Double buffer:
  - load copies the inputs into staging and sets load_pending.
  - at a frame wrap with load_pending = 1, active <= staging and load_pending clears.
  - load on the same cycle as the wrap: active <= old staging, staging <= new inputs, load_pending stays 1.
  - load while pending simply overwrites staging (last write wins).
- Blink:
  - a frame counter toggles the blink phase every BLINK_FRAMES frame wraps.
  - digits whose active blink bit = 1 are forced off (seg off, dig off) while phase = 1.
- Fault:
  - fault = 1 sets the latch in the same cycle it is sampled.
  - fault_clr clears the latch only if fault = 0 that cycle; fault = 1 dominates.
  - while latched, display shows "OvEr" on digits 3..0 (codes 20, 21, 14, 19), other digits blank, dp off.
  - the whole display blinks by phase, overriding blink_in.
  - the active buffer is untouched; loads are still accepted.
  - after clear, the normal active contents reappear at the next slot.
- Reset mid-frame: immediate outputs-off; any pending data is lost.

Decomposition:
- Package rover_display_pkg holds:
  - glyph code localparams (GLYPH_BLANK, GLYPH_DASH, GLYPH_L, ...);
  - the 7-bit segment constants;
  - the FAULT_MSG array {20, 21, 14, 19}.
- Sub-module rover_glyph_decode: purely combinational, 5-bit code to 7-bit segments. It is instantiated once, on the muxed current digit.

Test Plan:
1. Reset check, REFRESH_DIV=8, DEAD_CYCLES=2: hold reset low -> seg=8'hFF, dig=4'hF, frame_done=0. After release, the first enabled slot gives dig=4'b1110 with seg=8'hFF (blank, since no load has occurred).
2. Load with codes {7, 1, 0, 15} (digits 3..0), dp_in=4'b0100. Required:
   - load_pending=1 until the next frame_done, then 0;
   - slot 0 gives seg=8'b10001110 (F);
   - slot 2 gives seg=8'b01111001 (1 with DP);
   - slot 3 gives seg=8'b11111000 (7).
3. Dead time: at each slot start, dig=4'hF for exactly DEAD_CYCLES cycles, then one-hot-low. frame_done pulses once every 4*REFRESH_DIV cycles.
4. Load asserted on the wrap cycle: the display shows the previously staged frame for one more frame; the new data appears after the following frame_done.
5. Fault then clear:
   - assert fault -> fault_active=1 next cycle; digits 3..0 show o, u, E, r (seg 8'hA3, 8'hE3, 8'h86, 8'hAF), blanked on alternate BLINK_FRAMES periods.
   - fault_clr with fault=1 -> no effect.
   - fault_clr with fault=0 -> previous glyphs return.
6. Parameter sweep NUM_DIGITS=6, DIG_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0: dig is one-hot-high across 6 slots; segment for 0 = 8'h3F; blink_in[5]=1 blanks only digit 5 in phase 1.

Source files
------------

// File: rtl/rover_display_pkg.sv
// Glyph codes, segment fonts and the fault banner shared by the rover status display.
// Segment constants are gfedcba, active-high; polarity is applied only at the pins.
package rover_display_pkg;

  localparam logic [4:0] GLYPH_E     = 5'd14;
  localparam logic [4:0] GLYPH_BLANK = 5'd16;
  localparam logic [4:0] GLYPH_DASH  = 5'd17;
  localparam logic [4:0] GLYPH_L     = 5'd18;
  localparam logic [4:0] GLYPH_R     = 5'd19;
  localparam logic [4:0] GLYPH_O     = 5'd20;
  localparam logic [4:0] GLYPH_U     = 5'd21;
  localparam logic [4:0] GLYPH_P     = 5'd22;
  localparam logic [4:0] GLYPH_H     = 5'd23;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_O     = 7'h5C;
  localparam logic [6:0] SEG_U     = 7'h1C;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_H     = 7'h76;

  // Element n is the font for hex digit n (F listed first, so it lands at index 15).
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // "OvEr" banner: FAULT_MSG[d] is the code shown on digit d.
  localparam logic [3:0][4:0] FAULT_MSG = {GLYPH_O, GLYPH_U, GLYPH_E, GLYPH_R};

endpackage

// File: rtl/rover_glyph_decode.sv
// Combinational 5-bit glyph code to gfedcba segment pattern (active-high).
// Codes outside the hex range and the letter set decode to blank.
module rover_glyph_decode
  import rover_display_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (code_i < 5'd16) begin
      seg_o = HEX_FONT[code_i[3:0]];
    end else begin
      case (code_i)
        GLYPH_DASH: seg_o = SEG_DASH;
        GLYPH_L:    seg_o = SEG_L;
        GLYPH_R:    seg_o = SEG_R;
        GLYPH_O:    seg_o = SEG_O;
        GLYPH_U:    seg_o = SEG_U;
        GLYPH_P:    seg_o = SEG_P;
        GLYPH_H:    seg_o = SEG_H;
        default:    seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/rover_seg_display_mux.sv
// N-digit multiplexed 7-segment driver: double-buffered glyphs, dead time, blink, fault banner.
// Pins are registered one cycle behind the slot counters; no backpressure, loads are always accepted.
module rover_seg_display_mux
  import rover_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 65536,
  parameter int DEAD_CYCLES    = 64,
  parameter int BLINK_FRAMES   = 32,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic [5*NUM_DIGITS-1:0]   glyph_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  input  logic [NUM_DIGITS-1:0]     blink_i,
  input  logic                      fault_i,
  input  logic                      fault_clr_i,
  output logic [7:0]                seg_o,
  output logic [NUM_DIGITS-1:0]     dig_o,
  output logic                      frame_done_o,
  output logic                      load_pending_o,
  output logic                      fault_active_o
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_FRAMES - 1);

  localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  typedef logic [NUM_DIGITS-1:0][4:0] glyphs_t;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic                  phase_q, phase_d;
  glyphs_t               act_glyph_q, act_glyph_d, stg_glyph_q, stg_glyph_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0] act_blink_q, act_blink_d, stg_blink_q, stg_blink_d;
  logic                  pend_q, pend_d;
  logic                  fault_q, fault_d;
  logic                  frame_done_q, frame_done_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic                  slot_end, wrap;
  logic [2:0]            idx_ext;
  logic [4:0]            cur_code;
  logic                  cur_dp, cur_blink, digit_off;
  logic [6:0]            cur_font;
  logic [7:0]            seg_raw;
  logic [NUM_DIGITS-1:0] dig_raw;

  assign slot_end = (presc_q == PRESC_LAST);
  assign wrap     = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    presc_d      = slot_end ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    frm_d        = frm_q;
    phase_d      = phase_q;
    act_glyph_d  = act_glyph_q;
    act_dp_d     = act_dp_q;
    act_blink_d  = act_blink_q;
    stg_glyph_d  = stg_glyph_q;
    stg_dp_d     = stg_dp_q;
    stg_blink_d  = stg_blink_q;
    pend_d       = pend_q;
    fault_d      = fault_q;
    frame_done_d = wrap;

    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // Swap only at the frame boundary so a digit never shows half an update.
    if (wrap && pend_q) begin
      act_glyph_d = stg_glyph_q;
      act_dp_d    = stg_dp_q;
      act_blink_d = stg_blink_q;
      pend_d      = 1'b0;
    end
    if (load_i) begin
      stg_glyph_d = glyph_i;
      stg_dp_d    = dp_i;
      stg_blink_d = blink_i;
      pend_d      = 1'b1;
    end

    if (fault_i) begin
      fault_d = 1'b1;
    end else if (fault_clr_i) begin
      fault_d = 1'b0;
    end
  end

  always_comb begin
    idx_ext = 3'(idx_q);
    if (fault_q) begin
      cur_code  = (idx_ext < 3'd4) ? FAULT_MSG[idx_ext[1:0]] : GLYPH_BLANK;
      cur_dp    = 1'b0;
      cur_blink = 1'b1;
    end else begin
      cur_code  = act_glyph_q[idx_q];
      cur_dp    = act_dp_q[idx_q];
      cur_blink = act_blink_q[idx_q];
    end
  end

  rover_glyph_decode u_decode (
    .code_i (cur_code),
    .seg_o  (cur_font)
  );

  always_comb begin
    digit_off = (presc_q < DEAD_END) || (phase_q && cur_blink);
    seg_raw   = digit_off ? 8'h00 : {cur_dp, cur_font};
    dig_raw   = digit_off ? '0 : (NUM_DIGITS'(1) << idx_q);
    seg_d     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_d     = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b0;
      act_glyph_q  <= {NUM_DIGITS{GLYPH_BLANK}};
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      stg_glyph_q  <= {NUM_DIGITS{GLYPH_BLANK}};
      stg_dp_q     <= '0;
      stg_blink_q  <= '0;
      pend_q       <= 1'b0;
      fault_q      <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      act_glyph_q  <= act_glyph_d;
      act_dp_q     <= act_dp_d;
      act_blink_q  <= act_blink_d;
      stg_glyph_q  <= stg_glyph_d;
      stg_dp_q     <= stg_dp_d;
      stg_blink_q  <= stg_blink_d;
      pend_q       <= pend_d;
      fault_q      <= fault_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign seg_o          = seg_q;
  assign dig_o          = dig_q;
  assign frame_done_o   = frame_done_q;
  assign load_pending_o = pend_q;
  assign fault_active_o = fault_q;

endmodule

// File: tb/tb_rover_seg_display_mux.sv
// Bench for rover_seg_display_mux: two configurations, a time-arithmetic reference model,
// directed literal checks and a randomized run.
module tb_rover_seg_display_mux;

  localparam int RD = 8;
  localparam int DC = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, fault, fault_clr;
  logic [39:0] gl;
  logic [7:0]  dpv, blv;

  logic [7:0] seg_a, seg_b;
  logic [3:0] dig_a;
  logic [5:0] dig_b;
  logic       fd_a, fd_b, lp_a, lp_b, fa_a, fa_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rover_seg_display_mux #(
    .NUM_DIGITS(4), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load), .glyph_i(gl[19:0]), .dp_i(dpv[3:0]),
    .blink_i(blv[3:0]), .fault_i(fault), .fault_clr_i(fault_clr), .seg_o(seg_a),
    .dig_o(dig_a), .frame_done_o(fd_a), .load_pending_o(lp_a), .fault_active_o(fa_a)
  );

  rover_seg_display_mux #(
    .NUM_DIGITS(6), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load), .glyph_i(gl[29:0]), .dp_i(dpv[5:0]),
    .blink_i(blv[5:0]), .fault_i(fault), .fault_clr_i(fault_clr), .seg_o(seg_b),
    .dig_o(dig_b), .frame_done_o(fd_b), .load_pending_o(lp_b), .fault_active_o(fa_b)
  );

  function automatic logic [6:0] font(input int c);
    case (c)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
     12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
     17: return 7'h40; 18: return 7'h38; 19: return 7'h50; 20: return 7'h5C;
     21: return 7'h1C; 22: return 7'h73; 23: return 7'h76;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int fmsg(input int d);
    case (d)
      0: return 19;
      1: return 14;
      2: return 21;
      3: return 20;
      default: return 16;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = DUT A (4 digits, active-low), 1 = DUT B (6 digits, active-high).
  // m_c counts clock edges since reset release; slot/frame/phase follow from plain division.
  int       m_c;
  int       m_ag [2][8], m_sg [2][8];
  bit       m_ad [2][8], m_ab [2][8], m_sd [2][8], m_sb [2][8];
  bit       m_pend [2], m_flt [2];
  logic [7:0] e_seg [2], e_dig [2];
  bit       e_fd [2], e_lp [2], e_fa [2];
  bit       e_vld = 1'b0;

  initial begin : model
    int fl, p, i, ph, code, nd;
    bit off, dp, lowp;
    logic [7:0] sr, dr;
    m_c = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_c = 0;
        for (int d = 0; d < 2; d++) begin
          for (int k = 0; k < 8; k++) begin
            m_ag[d][k] = 16; m_ad[d][k] = 1'b0; m_ab[d][k] = 1'b0;
            m_sg[d][k] = 16; m_sd[d][k] = 1'b0; m_sb[d][k] = 1'b0;
          end
          m_pend[d] = 1'b0;
          m_flt[d]  = 1'b0;
          e_seg[d]  = (d == 0) ? 8'hFF : 8'h00;
          e_dig[d]  = (d == 0) ? 8'hFF : 8'h00;
          e_fd[d]   = 1'b0;
          e_lp[d]   = 1'b0;
          e_fa[d]   = 1'b0;
        end
        e_vld = 1'b1;
      end else begin
        for (int d = 0; d < 2; d++) begin
          nd   = (d == 0) ? 4 : 6;
          lowp = (d == 0);
          fl   = RD * nd;
          p    = m_c % RD;
          i    = (m_c / RD) % nd;
          ph   = ((m_c / fl) / BF) % 2;
          if (m_flt[d]) begin
            code = fmsg(i);
            dp   = 1'b0;
            off  = (p < DC) || (ph == 1);
          end else begin
            code = m_ag[d][i];
            dp   = m_ad[d][i];
            off  = (p < DC) || (ph == 1 && m_ab[d][i]);
          end
          sr       = off ? 8'h00 : {dp, font(code)};
          dr       = off ? 8'h00 : 8'(1 << i);
          e_seg[d] = lowp ? ~sr : sr;
          e_dig[d] = lowp ? ~dr : dr;
          e_fd[d]  = ((m_c + 1) % fl) == 0;
          if (e_fd[d] && m_pend[d]) begin
            for (int k = 0; k < 8; k++) begin
              m_ag[d][k] = m_sg[d][k]; m_ad[d][k] = m_sd[d][k]; m_ab[d][k] = m_sb[d][k];
            end
            m_pend[d] = 1'b0;
          end
          if (load) begin
            for (int k = 0; k < nd; k++) begin
              m_sg[d][k] = int'(gl[5*k +: 5]);
              m_sd[d][k] = dpv[k];
              m_sb[d][k] = blv[k];
            end
            m_pend[d] = 1'b1;
          end
          if (fault) m_flt[d] = 1'b1;
          else if (fault_clr) m_flt[d] = 1'b0;
          e_lp[d] = m_pend[d];
          e_fa[d] = m_flt[d];
        end
        m_c++;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (e_vld) begin
        chk("seg_a", seg_a, e_seg[0]);
        chk("dig_a", {4'h0, dig_a}, {4'h0, e_dig[0][3:0]});
        chk("frame_done_a", {7'h0, fd_a}, {7'h0, e_fd[0]});
        chk("load_pending_a", {7'h0, lp_a}, {7'h0, e_lp[0]});
        chk("fault_active_a", {7'h0, fa_a}, {7'h0, e_fa[0]});
        chk("seg_b", seg_b, e_seg[1]);
        chk("dig_b", {2'h0, dig_b}, {2'h0, e_dig[1][5:0]});
        chk("frame_done_b", {7'h0, fd_b}, {7'h0, e_fd[1]});
        chk("load_pending_b", {7'h0, lp_b}, {7'h0, e_lp[1]});
        chk("fault_active_b", {7'h0, fa_b}, {7'h0, e_fa[1]});
      end
    end
  end

  // Advance to the next negedge where the pins show digit idx just after dead time (ph < 0: any phase).
  task automatic wait_view(input int n, input int idx, input int ph);
    bit hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (m_c >= 1 && ((m_c - 1) % RD) == DC && (((m_c - 1) / RD) % n) == idx &&
          (ph < 0 || ((((m_c - 1) / (RD * n)) / BF) % 2) == ph))
        hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_view: slot %0d of %0d digits never reached", idx, n);
    end
  endtask

  initial begin : stim
    bit hit;
    rst_n = 1'b0; load = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    gl = '0; dpv = '0; blv = '0;
    repeat (3) @(negedge clk);
    chk("rst_seg_a", seg_a, 8'hFF);
    chk("rst_dig_a", {4'h0, dig_a}, 8'h0F);
    chk("rst_fd_a", {7'h0, fd_a}, 8'h00);
    chk("rst_seg_b", seg_b, 8'h00);
    chk("rst_dig_b", {2'h0, dig_b}, 8'h00);
    rst_n = 1'b1;

    wait_view(4, 0, -1);
    chk("first_slot_seg_a", seg_a, 8'hFF);
    chk("first_slot_dig_a", {4'h0, dig_a}, 8'h0E);

    gl = '0;
    gl[29:0] = {5'd8, 5'd8, 5'd7, 5'd1, 5'd0, 5'd15};
    dpv = 8'b0000_0100;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pending_after_load_a", {7'h0, lp_a}, 8'h01);
    wait_view(4, 0, -1);
    chk("slot0_F_a", seg_a, 8'h8E);
    chk("pending_cleared_a", {7'h0, lp_a}, 8'h00);
    wait_view(4, 2, -1);
    chk("slot2_1dp_a", seg_a, 8'h79);
    wait_view(4, 3, -1);
    chk("slot3_7_a", seg_a, 8'hF8);
    wait_view(6, 1, -1);
    chk("slot1_0_seg_b", seg_b, 8'h3F);
    chk("slot1_dig_b", {2'h0, dig_b}, 8'h02);

    // Stage all-8s, then load all-2s exactly on A's wrap edge.
    for (int k = 0; k < 8; k++) gl[5*k +: 5] = 5'd8;
    dpv = '0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (((m_c + 1) % (RD * 4)) == 0) hit = 1'b1;
      else @(negedge clk);
    end
    for (int k = 0; k < 8; k++) gl[5*k +: 5] = 5'd2;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_view(4, 0, -1);
    chk("wrap_load_old_a", seg_a, 8'h80);
    chk("wrap_load_pending_a", {7'h0, lp_a}, 8'h01);
    wait_view(4, 0, -1);
    chk("wrap_load_new_a", seg_a, 8'hA4);
    chk("wrap_load_done_a", {7'h0, lp_a}, 8'h00);

    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    chk("fault_latch_a", {7'h0, fa_a}, 8'h01);
    wait_view(4, 3, 0);
    chk("fault_o_a", seg_a, 8'hA3);
    wait_view(4, 2, 0);
    chk("fault_u_a", seg_a, 8'hE3);
    wait_view(4, 1, 0);
    chk("fault_E_a", seg_a, 8'h86);
    wait_view(4, 0, 0);
    chk("fault_r_a", seg_a, 8'hAF);
    wait_view(4, 0, 1);
    chk("fault_blink_seg_a", seg_a, 8'hFF);
    chk("fault_blink_dig_a", {4'h0, dig_a}, 8'h0F);
    fault = 1'b1;
    fault_clr = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    chk("clr_blocked_a", {7'h0, fa_a}, 8'h01);
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_done_a", {7'h0, fa_a}, 8'h00);
    wait_view(4, 0, 0);
    chk("restored_a", seg_a, 8'hA4);

    gl[29:20] = {5'd8, 5'd8};
    blv = 8'b0010_0000;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (fd_b) hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_done_b: no pulse within 200 cycles");
    end
    wait_view(6, 5, 1);
    chk("blink5_seg_b", seg_b, 8'h00);
    chk("blink5_dig_b", {2'h0, dig_b}, 8'h00);
    wait_view(6, 4, 1);
    chk("noblink4_seg_b", seg_b, 8'h7F);
    chk("noblink4_dig_b", {2'h0, dig_b}, 8'h10);
    wait_view(6, 5, 0);
    chk("blink5_on_dig_b", {2'h0, dig_b}, 8'h20);

    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      load = ($urandom_range(0, 15) == 0);
      if (load) begin
        gl  = 40'({$urandom(), $urandom()});
        dpv = 8'($urandom());
        blv = 8'($urandom() & $urandom());
      end
      fault     = ($urandom_range(0, 299) == 0);
      fault_clr = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    fault = 1'b0;
    fault_clr = 1'b0;
    gl = 40'({$urandom(), $urandom()});
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_seg_a", seg_a, 8'hFF);
    chk("midrst_dig_a", {4'h0, dig_a}, 8'h0F);
    chk("midrst_pending_a", {7'h0, lp_a}, 8'h00);
    chk("midrst_seg_b", seg_b, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
